// File: rtl/alu_op_sequencer.sv
// Three-state command sequencer that drives an external combinational ALU and
// writes results back into a private four-entry register file.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_func,
  input  logic [1:0] cmd_src_a,
  input  logic [1:0] cmd_src_b,
  input  logic [1:0] cmd_dst,
  input  logic [7:0] cmd_imm,
  output logic [7:0] alu_A,
  output logic [7:0] alu_B,
  output logic [3:0] alu_F,
  input  logic [7:0] alu_C,
  input  logic [1:0] alu_flags,
  output logic       done,
  output logic [7:0] result,
  output logic [1:0] status_flags,
  output logic       err
);

  localparam logic [1:0] OpAlu = 2'b00;
  localparam logic [1:0] OpLdi = 2'b01;

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e     state_q;
  logic [7:0] regs_q [4];
  logic [1:0] op_q;
  logic [3:0] func_q;
  logic [1:0] dst_q;
  logic [7:0] imm_q;
  logic [7:0] op_a_q;
  logic [7:0] op_b_q;
  logic [7:0] result_q;
  logic [1:0] flags_q;
  logic       done_q;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      op_q     <= '0;
      func_q   <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            // Operands are snapshotted here so a dst that aliases a source
            // still feeds the pre-write value to the ALU.
            op_q    <= cmd_op;
            func_q  <= cmd_func;
            dst_q   <= cmd_dst;
            imm_q   <= cmd_imm;
            op_a_q  <= regs_q[cmd_src_a];
            op_b_q  <= regs_q[cmd_src_b];
            state_q <= StIssue;
          end
        end
        StIssue: begin
          case (op_q)
            OpAlu: begin
              regs_q[dst_q] <= alu_C;
              result_q      <= alu_C;
              flags_q       <= alu_flags;
            end
            OpLdi: begin
              regs_q[dst_q] <= imm_q;
              result_q      <= imm_q;
            end
            default: err_q <= 1'b1;
          endcase
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic issue;
  assign issue = (state_q == StIssue);

  assign cmd_ready    = (state_q == StIdle);
  assign alu_A        = issue ? op_a_q : 8'h00;
  assign alu_B        = issue ? op_b_q : 8'h00;
  assign alu_F        = issue ? func_q : 4'h0;
  assign done         = done_q;
  assign err          = err_q;
  assign result       = result_q;
  assign status_flags = flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: stub adder ALU, directed scenarios, then random
// commands checked against an array-based reference model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_func;
  logic [1:0] cmd_src_a;
  logic [1:0] cmd_src_b;
  logic [1:0] cmd_dst;
  logic [7:0] cmd_imm;
  logic [7:0] alu_A;
  logic [7:0] alu_B;
  logic [3:0] alu_F;
  logic [7:0] alu_C;
  logic [1:0] alu_flags;
  logic       done;
  logic [7:0] result;
  logic [1:0] status_flags;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_r [4];
  logic [7:0] m_result;
  logic [1:0] m_flags;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_func     (cmd_func),
    .cmd_src_a    (cmd_src_a),
    .cmd_src_b    (cmd_src_b),
    .cmd_dst      (cmd_dst),
    .cmd_imm      (cmd_imm),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_F        (alu_F),
    .alu_C        (alu_C),
    .alu_flags    (alu_flags),
    .done         (done),
    .result       (result),
    .status_flags (status_flags),
    .err          (err)
  );

  // Stub ALU: 8-bit add, flags = {zero, carry}.
  logic [8:0] stub_sum;
  always_comb begin
    stub_sum  = {1'b0, alu_A} + {1'b0, alu_B};
    alu_C     = stub_sum[7:0];
    alu_flags = {(stub_sum[7:0] == 8'h00), stub_sum[8]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_result = 8'h00;
    m_flags  = 2'b00;
  endtask

  task automatic scramble_cmd();
    cmd_op    = 2'($urandom);
    cmd_func  = 4'($urandom);
    cmd_src_a = 2'($urandom);
    cmd_src_b = 2'($urandom);
    cmd_dst   = 2'($urandom);
    cmd_imm   = 8'($urandom);
  endtask

  task automatic check_outputs_idle(input string tag);
    check_eq({tag, "_ready"}, cmd_ready, 1);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_result"}, result, m_result);
    check_eq({tag, "_flags"}, status_flags, m_flags);
    check_eq({tag, "_aluA"}, alu_A, 0);
    check_eq({tag, "_aluB"}, alu_B, 0);
    check_eq({tag, "_aluF"}, alu_F, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after
  // cmd_ready is back, three cycles later. hold keeps cmd_valid asserted with
  // junk fields while the block is busy.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] func, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [1:0] dst, input logic [7:0] imm,
                         input bit hold);
    logic [7:0] ea, eb;
    logic [8:0] s;
    logic       eerr;
    check_eq("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_func = func; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = dst;
    cmd_imm = imm;
    ea = m_r[sa];
    eb = m_r[sb];
    @(posedge clk);
    @(negedge clk);
    check_eq("issue_ready", cmd_ready, 0);
    check_eq("issue_done", done, 0);
    check_eq("issue_aluA", alu_A, ea);
    check_eq("issue_aluB", alu_B, eb);
    check_eq("issue_aluF", alu_F, func);
    if (hold) scramble_cmd(); else cmd_valid = 1'b0;
    eerr = 1'b0;
    if (op == 2'b00) begin
      s = {1'b0, ea} + {1'b0, eb};
      m_r[dst] = s[7:0];
      m_result = s[7:0];
      m_flags  = {(s[7:0] == 8'h00), s[8]};
    end else if (op == 2'b01) begin
      m_r[dst] = imm;
      m_result = imm;
    end else begin
      eerr = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("done_pulse", done, 1);
    check_eq("done_err", err, eerr);
    check_eq("done_ready", cmd_ready, 0);
    check_eq("done_result", result, m_result);
    check_eq("done_flags", status_flags, m_flags);
    check_eq("done_aluA", alu_A, 0);
    if (hold) scramble_cmd();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("after_done", done, 0);
    check_eq("after_err", err, 0);
    check_eq("after_ready", cmd_ready, 1);
    check_eq("after_result", result, m_result);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    scramble_cmd();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_outputs_idle("reset");

    // Loads then an ALU op
    run_cmd(2'b01, 4'h0, 2'd0, 2'd0, 2'd1, 8'h05, 1'b0);
    check_eq("ld1_result", result, 8'h05);
    run_cmd(2'b01, 4'h0, 2'd0, 2'd0, 2'd2, 8'h03, 1'b0);
    check_eq("ld2_result", result, 8'h03);
    check_eq("ld2_flags", status_flags, 2'b00);
    run_cmd(2'b00, 4'hA, 2'd1, 2'd2, 2'd0, 8'h00, 1'b0);
    check_eq("alu_result", result, 8'h08);
    check_eq("alu_flags", status_flags, 2'b00);

    // Wrap-around with aliased operands and destination
    run_cmd(2'b01, 4'h0, 2'd0, 2'd0, 2'd3, 8'hFF, 1'b0);
    run_cmd(2'b00, 4'h3, 2'd3, 2'd3, 2'd3, 8'h00, 1'b0);
    check_eq("wrap_result", result, 8'hFE);
    check_eq("wrap_flags", status_flags, 2'b01);
    run_cmd(2'b01, 4'h0, 2'd0, 2'd0, 2'd1, 8'h02, 1'b0);
    check_eq("ldi_keeps_flags", status_flags, 2'b01);
    run_cmd(2'b00, 4'h7, 2'd1, 2'd3, 2'd2, 8'h00, 1'b0);
    check_eq("zero_result", result, 8'h00);
    check_eq("zero_flags", status_flags, 2'b11);

    // Busy with cmd_valid held, including reserved ops
    run_cmd(2'b11, 4'h1, 2'd0, 2'd1, 2'd0, 8'hAA, 1'b1);
    run_cmd(2'b10, 4'h2, 2'd2, 2'd3, 2'd1, 8'h55, 1'b1);
    run_cmd(2'b00, 4'h5, 2'd0, 2'd1, 2'd3, 8'h00, 1'b1);
    run_cmd(2'b00, 4'h9, 2'd3, 2'd0, 2'd0, 8'h00, 1'b0);

    // Reset while in ISSUE aborts the command
    cmd_valid = 1'b1;
    cmd_op = 2'b01; cmd_dst = 2'd0; cmd_imm = 8'h77;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_issue_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_outputs_idle("abort");
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_no_done", done, 0);
    run_cmd(2'b00, 4'h1, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0);
    run_cmd(2'b00, 4'h1, 2'd2, 2'd3, 2'd1, 8'h00, 1'b0);
    check_eq("abort_zero_flags", status_flags, 2'b10);

    // Command coincident with reset is dropped
    run_cmd(2'b01, 4'h0, 2'd0, 2'd0, 2'd2, 8'h3C, 1'b0);
    cmd_valid = 1'b1;
    cmd_op = 2'b01; cmd_dst = 2'd2; cmd_imm = 8'hC3;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cmd_valid = 1'b0;
    model_reset();
    check_outputs_idle("rst_cmd");
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_no_done", done, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    run_cmd(2'b00, 4'h0, 2'd2, 2'd2, 2'd3, 8'h00, 1'b0);

    // Random commands
    for (int k = 0; k < 300; k++) begin
      logic [1:0] rop;
      rop = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom);
      run_cmd(rop, 4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
              1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check_eq("idle_gap_ready", cmd_ready, 1);
        check_eq("idle_gap_done", done, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
